// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the 32-bit hex word shown on a scanned 8-digit active-low 7-segment bus
//   clk, rst_n (async active-low); an[7:0] anodes, seg[7:0] {dp,g..a}, both active-low
//   value[31:0], dp[7:0], digit_err[7:0] from the last complete frame; valid pulse; frame_cnt wraps
module seg_scan_decoder #(
  parameter int SETTLE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  an,
  input  logic [7:0]  seg,
  output logic [31:0] value,
  output logic [7:0]  dp,
  output logic [7:0]  digit_err,
  output logic        valid,
  output logic [15:0] frame_cnt
);
  localparam logic [15:0] SET = 16'(SETTLE);
  logic [7:0]  s_an, s_seg, seen, nx_seen, sh_dp, sh_err, nx_dp, nx_err;
  logic [15:0] cnt;
  logic [31:0] sh_val, nx_val;
  logic [3:0]  nib;
  logic [2:0]  idx;
  logic        same, cap, done, bad;
  assign same = {an, seg} == {s_an, s_seg};
  // cnt stops at SET, so a long dwell crosses SET-1 only once
  assign cap  = same && cnt == SET - 16'd1 && $onehot(~s_an);
  assign done = cap && nx_seen == 8'hFF;
  always_comb begin
    idx = '0;
    for (int k = 0; k < 8; k++)
      if (!s_an[k]) idx = 3'(k);
  end
  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (s_seg[6:0])
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h18: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: bad = 1'b1;
    endcase
  end
  // shadows with the digit under capture merged in, so completion sees its fresh data
  always_comb begin
    nx_val = sh_val;
    nx_dp = sh_dp;
    nx_err = sh_err;
    nx_seen = seen | (8'd1 << idx);
    nx_val[{idx, 2'b00} +: 4] = nib;
    nx_dp[idx] = ~s_seg[7];
    nx_err[idx] = bad;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_an <= 8'hFF;
      s_seg <= 8'hFF;
      cnt <= '0;
      seen <= '0;
      sh_val <= '0;
      sh_dp <= '0;
      sh_err <= '0;
      value <= '0;
      dp <= '0;
      digit_err <= '0;
      valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      s_an <= an;
      s_seg <= seg;
      cnt <= !same ? '0 : (cnt == SET ? cnt : cnt + 16'd1);
      valid <= done;
      if (cap) begin
        sh_val <= nx_val;
        sh_dp <= nx_dp;
        sh_err <= nx_err;
        seen <= done ? '0 : nx_seen;
      end
      if (done) begin
        value <= nx_val;
        dp <= nx_dp;
        digit_err <= nx_err;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed and randomized scans checked against a dwell-time behavioural model
module tb_seg_scan_decoder;
  localparam int SETTLE = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  an = 8'hFF, seg = 8'hFF;
  logic [31:0] value;
  logic [7:0]  dp, digit_err;
  logic        valid;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0, vcount = 0, v0;
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .value(value), .dp(dp),
    .digit_err(digit_err), .valid(valid), .frame_cnt(frame_cnt));
  always #5 clk = ~clk;
  int          ecnt = 0, chg = 0, md, mnib;
  logic [15:0] prev;
  int          sh_nib [8];
  logic [7:0]  sh_dp, sh_err, m_seen, m_dp, m_err;
  logic [31:0] m_value;
  logic        m_valid, merr;
  logic [15:0] m_frame;
  // a digit is taken once its pattern has been on the bus for exactly SETTLE edges after the change edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev = 16'hFFFF;
      chg = ecnt;
      for (int i = 0; i < 8; i++) sh_nib[i] = 0;
      sh_dp = 0;
      sh_err = 0;
      m_seen = 0;
      m_value = 0;
      m_dp = 0;
      m_err = 0;
      m_valid = 0;
      m_frame = 0;
    end else begin
      m_valid = 0;
      ecnt++;
      if ({an, seg} != prev) begin
        prev = {an, seg};
        chg = ecnt;
      end else if (ecnt - chg == SETTLE && $countones(~an) == 1) begin
        for (int i = 0; i < 8; i++) if (!an[i]) md = i;
        mnib = 0;
        merr = 1;
        for (int j = 0; j < 16; j++)
          if (glyph[j] == seg[6:0]) begin
            mnib = j;
            merr = 0;
          end
        sh_nib[md] = mnib;
        sh_dp[md] = ~seg[7];
        sh_err[md] = merr;
        m_seen[md] = 1;
        if (m_seen == 8'hFF) begin
          for (int i = 0; i < 8; i++) m_value[i*4 +: 4] = 4'(sh_nib[i]);
          m_dp = sh_dp;
          m_err = sh_err;
          m_valid = 1;
          m_frame = m_frame + 16'd1;
          m_seen = 0;
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk("value", value, m_value);
      chk("dp", {24'd0, dp}, {24'd0, m_dp});
      chk("digit_err", {24'd0, digit_err}, {24'd0, m_err});
      chk("valid", {31'd0, valid}, {31'd0, m_valid});
      chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_frame});
      if (valid) vcount++;
    end
  end
  task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask
  task automatic show(input int d, input logic [3:0] v, input logic dpon, input int n);
    hold(~(8'd1 << d), {~dpon, glyph[v]}, n);
  endtask
  task automatic scan(input logic [31:0] w, input int ndig);
    for (int d = 0; d < ndig; d++) show(d, w[d*4 +: 4], 1'b0, 8);
    hold(8'hFF, 8'hFF, 4);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    an = 8'hFF;
    seg = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_value", value, 32'h0);
    chk("rst_dp_err", {dp, digit_err}, 32'h0);
    chk("rst_valid_cnt", {valid, frame_cnt}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] w;
    logic [7:0]  dm;
    int          ord [8];
    int          t, r;
    @(negedge clk);
    do_reset();
    v0 = vcount;
    scan(32'h1234ABCD, 8);
    chk("clean_value", value, 32'h1234ABCD);
    chk("clean_dp_err", {dp, digit_err}, 32'h0);
    chk("clean_frames", {16'd0, frame_cnt}, 32'd1);
    chk("clean_pulses", vcount - v0, 1);
    do_reset();
    v0 = vcount;
    for (int d = 0; d < 8; d++) show(d, 4'(d), 1'b0, d == 3 ? 3 : 8);
    hold(8'hFF, 8'hFF, 4);
    chk("glitch_no_pulse", vcount - v0, 0);
    chk("glitch_no_frame", {16'd0, frame_cnt}, 32'd0);
    show(3, 4'd3, 1'b0, 8);
    hold(8'hFF, 8'hFF, 4);
    chk("glitch_pulse", vcount - v0, 1);
    chk("glitch_value", value, 32'h76543210);
    do_reset();
    for (int d = 0; d < 8; d++)
      if (d == 5) hold(8'hDF, 8'h7F, 8);
      else show(d, 4'd0, 1'b0, 8);
    hold(8'hFF, 8'hFF, 4);
    chk("illegal_err", {24'd0, digit_err}, 32'h20);
    chk("illegal_dp", {24'd0, dp}, 32'h20);
    chk("illegal_value", value, 32'h0);
    do_reset();
    v0 = vcount;
    hold(8'hFC, 8'hC0, 20);
    hold(8'hFF, 8'hC0, 20);
    chk("badan_no_pulse", vcount - v0, 0);
    chk("badan_no_frame", {16'd0, frame_cnt}, 32'd0);
    show(2, 4'd7, 1'b0, 8);
    show(0, 4'd0, 1'b0, 8);
    show(1, 4'd0, 1'b0, 8);
    show(3, 4'd0, 1'b0, 8);
    show(2, 4'd9, 1'b0, 8);
    for (int d = 4; d < 8; d++) show(d, 4'd0, 1'b0, 8);
    hold(8'hFF, 8'hFF, 4);
    chk("recap_value", value, 32'h00000900);
    chk("recap_pulse", vcount - v0, 1);
    do_reset();
    scan(32'hDEADBEEF, 5);
    do_reset();
    scan(32'hDEADBEEF, 8);
    chk("rstmid_value", value, 32'hDEADBEEF);
    chk("rstmid_frames", {16'd0, frame_cnt}, 32'd1);
    @(posedge clk);
    #1;
    force dut.frame_cnt = 16'hFFFF;
    m_frame = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    @(negedge clk);
    v0 = vcount;
    scan(32'hCAFE0123, 8);
    chk("wrap_frames", {16'd0, frame_cnt}, 32'd0);
    chk("wrap_pulse", vcount - v0, 1);
    chk("wrap_value", value, 32'hCAFE0123);
    for (int f = 0; f < 40; f++) begin
      w = $urandom;
      dm = 8'($urandom);
      for (int i = 0; i < 8; i++) ord[i] = i;
      for (int i = 7; i > 0; i--) begin
        r = $urandom_range(0, i);
        t = ord[i];
        ord[i] = ord[r];
        ord[r] = t;
      end
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 9) == 0) hold(8'($urandom), 8'($urandom), $urandom_range(1, SETTLE));
        if ($urandom_range(0, 7) == 0) hold(~(8'd1 << ord[i]), 8'($urandom), $urandom_range(SETTLE, SETTLE + 4));
        else hold(~(8'd1 << ord[i]), {~dm[ord[i]], glyph[w[ord[i]*4 +: 4]]}, $urandom_range(SETTLE, SETTLE + 4));
      end
      if ($urandom_range(0, 3) == 0) hold(8'hFF, 8'hFF, $urandom_range(1, 6));
    end
    hold(8'hFF, 8'hFF, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Decodes a multiplexed 8-digit, active-low seven-segment display bus back into the 32-bit hex value being shown. It watches the anode and segment lines driven by the display scanner, waits until each digit is stable, and rebuilds the full word with per-digit validity and decimal-point flags. It sits beside the display driver as a self-check and debug monitor for the CPU's on-board display path.

## Interface
- `SETTLE`, default 16: consecutive equal samples needed before a digit is captured; legal range 1..65535.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `an` input 8: anode enables, active-low; bit i selects digit i (digit 0 = least-significant nibble); synchronous to `clk`.
- `seg` input 8: segment pattern, active-low; bit7 = DP, bits 6..0 = segments g..a; synchronous to `clk`.
- `value` output 32: last completed frame; nibble i = digit i.
- `dp` output 8: bit i = 1 if digit i's DP was lit (`seg[7]` = 0) in the last frame.
- `digit_err` output 8: bit i = 1 if digit i's pattern was not a legal hex glyph in the last frame.
- `valid` output 1: one-cycle pulse when `value`/`dp`/`digit_err` update.
- `frame_cnt` output 16: number of completed frames, wraps 0xFFFF -> 0x0000.

## Operation
- Glyph table on `seg[6:0]`: 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x18→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F. Any other code → nibble 0, err = 1. `seg[7]` never affects the nibble.
- Sample register `s_an`/`s_seg` loads `an`/`seg` every cycle. Stability counter `cnt`:
  - cleared when the incoming `{an,seg}` differs from the sample register;
  - otherwise increments, saturating at `SETTLE`.
- Capture fires on the edge where `cnt` goes from SETTLE-1 to SETTLE. A capture requires exactly one bit of `s_an` low. Zero or multiple low bits mean blanking or a glitch: no capture and no error.
  - Capture writes the shadow nibble, shadow dp and shadow err for that digit and sets `seen[i]`.
  - At most one capture per stable dwell. Saturation prevents a second capture.
- Recapture of a digit already in `seen` before the frame completes overwrites its shadow entry. The newest data wins.
- Frame completion: on the edge where a capture makes `seen` = 0xFF:
  - load `value`, `dp`, `digit_err` from the shadows, using the just-captured digit's new data;
  - assert `valid`;
  - increment `frame_cnt`;
  - clear `seen` to 0.
- Shadows are not cleared between frames. Digits are accepted in any order.

## Timing
- Reset (async assert, sync-released use): `value` = 0, `dp` = 0, `digit_err` = 0, `valid` = 0, `frame_cnt` = 0, `seen` = 0, `cnt` = 0, sample registers = 0xFF. Shadows = 0.
- Reset mid-frame discards partial captures. The next frame needs all 8 digits again.
- Capture latency: inputs changed before edge E0 and held constant. Capture occurs at edge E0+SETTLE. For SETTLE = 1, the minimum dwell is 2 edges.
- `valid` is high for exactly the one cycle following the completing capture edge, and never two cycles in a row. Outputs hold until the next completion.
- If any change occurs within a dwell, `cnt` restarts at 0 on that edge.

## Test plan
- **Clean frame.** SETTLE = 4. Scan 0x1234ABCD, digits 0..7, each held 8 cycles, DP off. Required: one `valid` pulse after digit 7's capture edge, `value` = 0x1234ABCD, `dp` = 0x00, `digit_err` = 0x00, `frame_cnt` = 1.
- **Glitch rejection.** Digit 3 is held only 3 cycles (SETTLE = 4), then all digits are held normally. Required: a short dwell never captures, and no `valid` appears until digit 3 gets a full dwell.
- **Illegal glyph and DP.** Digit 5 `seg` = 0x7F (blank, DP lit), others show 0x00000000. Required: `digit_err` = 0x20, `dp` = 0x20, nibble 5 = 0.
- **Bad anodes and recapture.**
  - `an` = 0xFC and `an` = 0xFF, each held 20 cycles: no capture.
  - Digit 2 shown as 7, then as 9 before the frame completes: final nibble 2 = 9.
- **Reset mid-frame.** Assert `rst_n` low after 5 digits are captured. Required: all outputs 0. A new full scan of 0xDEADBEEF gives `value` = 0xDEADBEEF, `frame_cnt` = 1.
- **Counter wrap.** Preload 0xFFFF completed frames (or force `frame_cnt`), then complete one more frame. Required: `frame_cnt` = 0x0000 and `valid` pulses once.
